addsub_multicycle: RTL

Parametrised multi-cycle adder/subtractor. It is the successor to the fixed 4-bit combinational add/sub.
- Adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per clock.
- Control is a start/busy/done handshake.
- Reports carry/borrow, signed overflow and zero flags.
- Intended for wide datapaths where a full-width ripple carry would not close timing.

---
 rtl/addsub_multicycle.sv | 130 +++++++++++++
 1 files changed

// File: rtl/addsub_multicycle.sv
// Multi-cycle adder/subtractor: processes WIDTH-bit operands CHUNK bits per clock
// with a start/busy/done handshake and registered carry, overflow and zero flags.
module addsub_multicycle #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [CHUNK:0]   slice_sum;
    logic             msb_cin;
    logic [WIDTH-1:0] acc_next;

    // Operands shift right each cycle so the active slice is always the low CHUNK bits;
    // the accumulator fills from the top so it is aligned after the last slice.
    always_comb begin
        slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        msb_cin   = slice_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
        acc_next  = (acc_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{m}};
                    carry_d = m;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_sum[CHUNK];
                acc_d   = acc_next;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(N - 1)) begin
                    state_d = S_IDLE;
                    sum_d   = acc_next;
                    cout_d  = slice_sum[CHUNK];
                    ovf_d   = msb_cin ^ slice_sum[CHUNK];
                    zero_d  = (acc_next == '0);
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
